diff_lane_sched: RTL and testbench
==================================

// Module: diff_lane_sched
// PURPOSE
//  Round-robin scheduler that time-shares one registered sample differencer among NCH ECG leads.
//  Accepts per-lead samples over valid/ready and keeps each lead's previous sample.
//  Issues (current, previous) operand pairs to the shared subtracter.
//  Re-tags each returning difference with its lead index. Sits between lead input buffers and the shared subtracter.
// PARAMETERS
//  NCH      4   number of leads sharing the subtracter (>=2)
//  DW       8   signed sample width
//  SUB_LAT  1   subtracter latency, operands -> result, in clk cycles (>=1)
//  CW       $clog2(NCH)  lead index width (derived, localparam)
// PORTS
//  clk         in   1         clock; all state updates on posedge
//  rst_n       in   1         asynchronous active-low reset
//  clr         in   1         sync flush of per-lead history
//  in_valid    in   NCH       lead i has a sample
//  in_data     in   NCH*DW    lead i sample, signed, bits [i*DW +: DW]
//  in_ready    out  NCH       one-hot grant; sample i accepted when in_valid[i]&in_ready[i]
//  sub_a       out  DW        to subtracter data_a (current sample), registered
//  sub_b       out  DW        to subtracter data_b (previous sample), registered
//  sub_result  in   DW+1      subtracter result = sub_a - sub_b, SUB_LAT cycles after operands
//  out_valid   out  1         difference valid (1-cycle pulse per result)
//  out_ch      out  CW        lead index of out_diff
//  out_diff    out  DW+1      signed difference, equals sub_result
// BEHAVIOUR
//  Reset (async): all registers cleared.
//   - Outputs: in_ready=0, sub_a=0, sub_b=0, out_valid=0, out_ch=0.
//   - Internal: prev[i]=0, primed[i]=0, rr_ptr=0, tag pipeline valid bits=0.
//   - Reset mid-operation discards in-flight results; no out_valid until new accepts.
//  Arbitration (combinational grant):
//   - Search in_valid starting at rr_ptr, wrapping NCH-1 -> 0.
//   - in_ready = one-hot of the first set lead, else 0.
//   - At most one accept per cycle; in_ready never asserts for a lead with in_valid=0.
//   - clr=1 forces in_ready=0 that cycle.
//  rr_ptr: on accept of lead g, rr_ptr <= (g==NCH-1)?0:g+1; unchanged when no accept.
//  Accept of lead g at cycle T:
//   - If primed[g]=1:
//     - Cycle T+1: sub_a<=in_data[g], sub_b<=prev[g].
//     - Enter tag {v=1,ch=g} into a SUB_LAT+1 stage shift pipe.
//   - If primed[g]=0 (first sample since reset/clr):
//     - No issue (tag v=0).
//     - sub_a/sub_b hold their previous values.
//   - Always at T+1: prev[g]<=in_data[g], primed[g]<=1.
//  Output timing:
//   - out_valid/out_ch are the pipe tail; out_diff=sub_result.
//   - A primed accept at T yields out_valid at cycle T+1+SUB_LAT.
//   - Throughput: 1 result/cycle sustained; results emerge in accept order.
//  Width: out_diff is DW+1 bit signed; range -(2^DW-1)..+(2^DW-1). Never overflows; no saturation.
//  No output backpressure: the consumer must absorb one result per cycle.
//  clr:
//   - Next edge: primed[*]<=0, prev[*]<=0.
//   - Ops already issued still complete and emit normally.
//   - rr_ptr is not changed.
//  Simultaneous accept and clr: impossible (clr masks in_ready).
//  Lead valid held without grant keeps its data stable; in_valid may not drop before in_ready (source rule, assert in bench).
// TESTING
//  1. Single lead: lead0 samples 10,15,12, one per cycle, SUB_LAT=1.
//     -> 1st suppressed.
//     -> out {ch0,+5} 2 cycles after 2nd accept.
//     -> next cycle {ch0,-3}.
//  2. Extremes: lead1 -128 then 127 -> out_diff=+255; then -128 -> out_diff=-255 (9-bit exact).
//  3. All 4 leads valid every cycle.
//     -> grants 0,1,2,3,0,... with exactly one in_ready bit per cycle.
//     -> after priming, out_valid continuous, out_ch tracking grant order delayed by 2.
//  4. Fairness: leads 0,2 valid, rr_ptr=1 -> grant 2, then 0, then 2; lead 1/3 never granted.
//  5. clr asserted mid-stream with one op in flight.
//     -> in-flight result emitted.
//     -> in_ready=0 during clr.
//     -> next sample per lead suppressed.
//     -> following sample diffs against post-clr value.
//  6. rst_n pulsed low between accept and result.
//     -> out_valid stays 0.
//     -> sub_a=sub_b=0.
//     -> first post-reset sample per lead suppressed.

Source files
------------

// File: rtl/diff_lane_sched.sv
// Round-robin front end that time-shares one registered sample differencer among NCH leads.
// Keeps each lead's previous sample, issues (current, previous) pairs and re-tags returning differences.
module diff_lane_sched #(
   parameter int NCH     = 4,
   parameter int DW      = 8,
   parameter int SUB_LAT = 1,
   localparam int CW     = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [NCH-1:0]    in_valid,
   input  logic [NCH*DW-1:0] in_data,
   output logic [NCH-1:0]    in_ready,
   output logic [DW-1:0]     sub_a,
   output logic [DW-1:0]     sub_b,
   input  logic [DW:0]       sub_result,
   output logic              out_valid,
   output logic [CW-1:0]     out_ch,
   output logic [DW:0]       out_diff
);

   // Handshake: lead i's sample is taken on a rising edge where in_valid[i] & in_ready[i];
   // a lead holding in_valid without a grant keeps in_data stable, and there is no output backpressure.

   logic [CW-1:0] rr_ptr_q, rr_ptr_d;
   logic [NCH-1:0] primed_q, primed_d;
   logic [DW-1:0] prev_q [NCH];
   logic [DW-1:0] prev_d [NCH];
   logic [DW-1:0] sub_a_q, sub_a_d;
   logic [DW-1:0] sub_b_q, sub_b_d;
   logic [SUB_LAT:0] tag_v_q, tag_v_d;
   logic [CW-1:0] tag_ch_q [SUB_LAT+1];
   logic [CW-1:0] tag_ch_d [SUB_LAT+1];

   logic          found;
   logic          accept;
   logic          issue;
   logic [CW-1:0] gnt_idx;
   logic [CW:0]   idx;
   logic [DW-1:0] gnt_data;
   logic [DW-1:0] gnt_prev;
   logic          gnt_primed;

   // Arbitration: first valid lead at or after rr_ptr, wrapping; clr suppresses any grant.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = 0; k < NCH; k++) begin
         idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
         if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
         if (!found && in_valid[idx[CW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = idx[CW-1:0];
         end
      end
      accept = found && !clr;
   end

   always_comb begin
      gnt_data   = '0;
      gnt_prev   = '0;
      gnt_primed = 1'b0;
      in_ready   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt_idx == CW'(k)) begin
            gnt_data   = in_data[k*DW +: DW];
            gnt_prev   = prev_q[k];
            gnt_primed = primed_q[k];
            in_ready[k] = accept;
         end
      end
      issue = accept && gnt_primed;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      primed_d = primed_q;
      sub_a_d  = sub_a_q;
      sub_b_d  = sub_b_q;
      for (int k = 0; k < NCH; k++) prev_d[k] = prev_q[k];

      if (accept) rr_ptr_d = (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + CW'(1);

      // clr and accept are mutually exclusive because clr masks the grant.
      if (clr) begin
         primed_d = '0;
         for (int k = 0; k < NCH; k++) prev_d[k] = '0;
      end else if (accept) begin
         for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == CW'(k)) begin
               prev_d[k]   = gnt_data;
               primed_d[k] = 1'b1;
            end
         end
      end

      if (issue) begin
         sub_a_d = gnt_data;
         sub_b_d = gnt_prev;
      end

      // Tag pipe runs alongside the operand register and the subtracter latency.
      tag_v_d     = {tag_v_q[SUB_LAT-1:0], issue};
      tag_ch_d[0] = gnt_idx;
      for (int k = 1; k <= SUB_LAT; k++) tag_ch_d[k] = tag_ch_q[k-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         primed_q <= '0;
         sub_a_q  <= '0;
         sub_b_q  <= '0;
         tag_v_q  <= '0;
         for (int k = 0; k < NCH; k++) prev_q[k] <= '0;
         for (int k = 0; k <= SUB_LAT; k++) tag_ch_q[k] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         primed_q <= primed_d;
         sub_a_q  <= sub_a_d;
         sub_b_q  <= sub_b_d;
         tag_v_q  <= tag_v_d;
         for (int k = 0; k < NCH; k++) prev_q[k] <= prev_d[k];
         for (int k = 0; k <= SUB_LAT; k++) tag_ch_q[k] <= tag_ch_d[k];
      end
   end

   assign sub_a     = sub_a_q;
   assign sub_b     = sub_b_q;
   assign out_valid = tag_v_q[SUB_LAT];
   assign out_ch    = tag_ch_q[SUB_LAT];
   assign out_diff  = sub_result;

endmodule

// File: tb/tb_diff_lane_sched.sv
// Directed bench for diff_lane_sched: hand-computed differences go into a scoreboard queue
// tagged with their due cycle; a negedge monitor pops and compares every out_valid.
module tb_diff_lane_sched;

   localparam int NCH     = 4;
   localparam int DW      = 8;
   localparam int SUB_LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr = 1'b0;
   logic [3:0]  in_valid = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_ready;
   logic [7:0]  sub_a;
   logic [7:0]  sub_b;
   logic [8:0]  sub_result;
   logic        out_valid;
   logic [1:0]  out_ch;
   logic [8:0]  out_diff;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;
   logic [26:0] exp_q[$];   // {due_cycle[15:0], ch[1:0], diff[8:0]}

   diff_lane_sched #(.NCH(NCH), .DW(DW), .SUB_LAT(SUB_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .sub_a(sub_a), .sub_b(sub_b), .sub_result(sub_result),
      .out_valid(out_valid), .out_ch(out_ch), .out_diff(out_diff)
   );

   // clock / reset / external subtracter (one registered stage)
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sub_result <= '0;
      else        sub_result <= {sub_a[7], sub_a} - {sub_b[7], sub_b};
   end

   // driver tasks
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   task automatic set_d(input int lane, input int val);
      in_data[lane*8 +: 8] = val[7:0];
   endtask

   task automatic exp_out(input int ch, input int diff);
      logic [8:0]  d;
      logic [1:0]  c;
      logic [15:0] t;
      d = diff[8:0];
      c = ch[1:0];
      t = cyc_cnt[15:0] + 16'(1 + SUB_LAT);
      exp_q.push_back({t, c, d});
   endtask

   task automatic cyc(input logic [3:0] v, input logic [3:0] er, input logic c);
      in_valid = v;
      clr      = c;
      @(negedge clk);
      chk("in_ready", {28'd0, in_ready}, {28'd0, er});
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [26:0] e;
      if (out_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: got ch=%0d diff=%0d at cycle %0d, expected no result",
                     out_ch, $signed(out_diff), cyc_cnt);
         end else begin
            e = exp_q.pop_front();
            if ({cyc_cnt[15:0], out_ch, out_diff} !== e) begin
               n_err++;
               $display("FAIL out_result: got cycle=%0d ch=%0d diff=%0d, expected cycle=%0d ch=%0d diff=%0d",
                        cyc_cnt, out_ch, $signed(out_diff), e[26:11], e[10:9], $signed(e[8:0]));
            end
         end
      end
      if (exp_q.size() > 0 && exp_q[0][26:11] <= cyc_cnt[15:0]) begin
         e = exp_q.pop_front();
         n_err++;
         $display("FAIL out_missing: got no result by cycle %0d, expected ch=%0d diff=%0d at cycle %0d",
                  cyc_cnt, e[10:9], $signed(e[8:0]), e[26:11]);
      end
   end

   // source rule: a valid lead without grant holds valid and data
   logic [3:0]  vp, rp;
   logic [31:0] dp;
   logic        have_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n && have_prev) begin
         for (int i = 0; i < 4; i++) begin
            if (vp[i] && !rp[i] && (!in_valid[i] || in_data[i*8 +: 8] != dp[i*8 +: 8])) begin
               n_err++;
               $display("FAIL source_hold lead %0d: got valid=%0b data=%0h, expected valid=1 data=%0h",
                        i, in_valid[i], in_data[i*8 +: 8], dp[i*8 +: 8]);
            end
         end
      end
      vp = in_valid;
      rp = in_ready;
      dp = in_data;
      have_prev = rst_n;
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
      chk("rst_sub_a", {24'd0, sub_a}, 32'd0);
      chk("rst_sub_b", {24'd0, sub_b}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single lead 10,15,12
      set_d(0, 10);                  cyc(4'b0001, 4'b0001, 1'b0);
      set_d(0, 15); exp_out(0, 5);   cyc(4'b0001, 4'b0001, 1'b0);
      set_d(0, 12); exp_out(0, -3);  cyc(4'b0001, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);

      // extremes on lead 1
      set_d(1, -128);                cyc(4'b0010, 4'b0010, 1'b0);
      set_d(1, 127);  exp_out(1, 255);  cyc(4'b0010, 4'b0010, 1'b0);
      set_d(1, -128); exp_out(1, -255); cyc(4'b0010, 4'b0010, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);

      // all leads valid, rr_ptr starts at 2
      set_d(0, 20); set_d(1, -100); set_d(2, 50); set_d(3, -50);
      cyc(4'b1111, 4'b0100, 1'b0); set_d(2, 60);
      cyc(4'b1111, 4'b1000, 1'b0); set_d(3, -70);
      exp_out(0, 8);   cyc(4'b1111, 4'b0001, 1'b0); set_d(0, 5);
      exp_out(1, 28);  cyc(4'b1111, 4'b0010, 1'b0); set_d(1, -90);
      exp_out(2, 10);  cyc(4'b1111, 4'b0100, 1'b0); set_d(2, 62);
      exp_out(3, -20); cyc(4'b1111, 4'b1000, 1'b0); set_d(3, -75);
      exp_out(0, -15); cyc(4'b1111, 4'b0001, 1'b0); set_d(0, 9);
      exp_out(1, 10);  cyc(4'b1111, 4'b0010, 1'b0);
      exp_out(2, 2);   cyc(4'b1101, 4'b0100, 1'b0);
      exp_out(3, -5);  cyc(4'b1001, 4'b1000, 1'b0);
      exp_out(0, 4);   cyc(4'b0001, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);

      // fairness: leads 0 and 2 with rr_ptr at 1
      set_d(0, 20); set_d(2, 61);
      exp_out(2, -1); cyc(4'b0101, 4'b0100, 1'b0); set_d(2, 64);
      exp_out(0, 11); cyc(4'b0101, 4'b0001, 1'b0); set_d(0, 25);
      exp_out(2, 3);  cyc(4'b0101, 4'b0100, 1'b0);
      exp_out(0, 5);  cyc(4'b0001, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);

      // clr with an op in flight
      set_d(3, -60); exp_out(3, 15); cyc(4'b1000, 4'b1000, 1'b0);
      set_d(3, -55);                 cyc(4'b1000, 4'b0000, 1'b1);
      set_d(0, 100);                 cyc(4'b1001, 4'b0001, 1'b0);
      set_d(0, 90);                  cyc(4'b1001, 4'b1000, 1'b0);
      set_d(3, -50); exp_out(0, -10); cyc(4'b1001, 4'b0001, 1'b0);
      exp_out(3, 5);                 cyc(4'b1000, 4'b1000, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);

      // reset between accept and result
      set_d(1, -80); cyc(4'b0010, 4'b0010, 1'b0);
      rst_n = 1'b0;
      in_valid = '0;
      @(negedge clk);
      chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_sub_a", {24'd0, sub_a}, 32'd0);
      chk("rst2_sub_b", {24'd0, sub_b}, 32'd0);
      chk("rst2_out_ch", {30'd0, out_ch}, 32'd0);
      chk("rst2_in_ready", {28'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) cyc(4'b0000, 4'b0000, 1'b0);
      cyc(4'b0010, 4'b0010, 1'b0);
      set_d(1, -70); exp_out(1, 10); cyc(4'b0010, 4'b0010, 1'b0);
      repeat (4) cyc(4'b0000, 4'b0000, 1'b0);

      chk("drain_queue", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
